level_controller: RTL and testbench

//  Sequences one gameplay level after the top-level game FSM enables it: pre-level countdown, timed play,

---
 rtl/level_pkg.sv | 20 ++
 rtl/level_if.sv | 29 ++
 rtl/level_sec_timer.sv | 27 ++
 rtl/level_controller.sv | 143 ++++++++++++++
 tb/tb_level_controller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/level_pkg.sv
// Shared types and constants for the level controller slice.
package level_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        RESPAWN   = 3'd4,
        DONE      = 3'd5,
        FAIL      = 3'd6
    } level_state_t;

    localparam logic [1:0] LEVEL_EASY = 2'd0;
    localparam logic [1:0] LEVEL_MED  = 2'd1;

    localparam int LIVES_W = 2;
    localparam int TIME_W  = 8;

endpackage

// File: rtl/level_if.sv
// Signals between the game FSM / level datapath (master) and the level controller (slave).
interface level_if;
    import level_pkg::*;

    logic                frameTick;
    logic                levelStart;
    logic [1:0]          levelId;
    logic                pauseBtn;
    logic                playerHit;
    logic                goalReached;
    logic                levelDone;
    logic                levelFail;
    logic                playing;
    logic [LIVES_W-1:0]  lives;
    logic [TIME_W-1:0]   timeLeft;
    logic [1:0]          countdown;
    level_state_t        stateOut;

    modport master (
        output frameTick, levelStart, levelId, pauseBtn, playerHit, goalReached,
        input  levelDone, levelFail, playing, lives, timeLeft, countdown, stateOut
    );

    modport slave (
        input  frameTick, levelStart, levelId, pauseBtn, playerHit, goalReached,
        output levelDone, levelFail, playing, lives, timeLeft, countdown, stateOut
    );

endinterface

// File: rtl/level_sec_timer.sv
// Divides frameTick down to a one-cycle secTick; clear wins over enable.
module level_sec_timer #(
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic Clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic secTick
);

    localparam int                CNT_W = $clog2(FRAMES_PER_SEC);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAMES_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    // Fires in the same cycle as the frameTick that wraps the count.
    assign secTick = en && !clr && (cnt == LAST);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)        cnt <= '0;
        else if (clr)     cnt <= '0;
        else if (secTick) cnt <= '0;
        else if (en)      cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/level_controller.sv
// Per-level sequencer: countdown, timed play, lives/respawn, win/fail.
// Optional pause support is compiled in with `define LEVEL_PAUSE_EN.
module level_controller
    import level_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNTDOWN_SEC  = 3,
    parameter int LIVES_INIT     = 3,
    parameter int TIME_EASY      = 90,
    parameter int TIME_MED       = 60,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic    Clk,
    input  logic    reset,
    level_if.slave  lc
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [TIME_W-1:0]  TIME_E     = TIME_W'(TIME_EASY);
    localparam logic [TIME_W-1:0]  TIME_M     = TIME_W'(TIME_MED);
    localparam logic [1:0]         CD_LOAD    = 2'(COUNTDOWN_SEC);
    localparam logic [7:0]         RESP_LOAD  = 8'(RESPAWN_FRAMES);

    level_state_t        state, state_n;
    logic [LIVES_W-1:0]  lives, lives_n;
    logic [TIME_W-1:0]   timeq, timeq_n;
    logic [1:0]          cd, cd_n;
    logic [7:0]          resp, resp_n;
    logic                secTick, timerEn, timerClr, pauseEdge;

    assign timerEn  = lc.frameTick && (state == COUNTDOWN || state == PLAY);
    assign timerClr = (state == IDLE) || !lc.levelStart;

    level_sec_timer #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_sec (
        .Clk     (Clk),
        .reset   (reset),
        .en      (timerEn),
        .clr     (timerClr),
        .secTick (secTick)
    );

`ifdef LEVEL_PAUSE_EN
    logic pausePrev;
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) pausePrev <= 1'b0;
        else       pausePrev <= lc.pauseBtn;
    end
    assign pauseEdge = lc.pauseBtn && !pausePrev;
`else
    logic pause_unused;
    assign pause_unused = lc.pauseBtn;
    assign pauseEdge    = 1'b0;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lives <= '0;
            timeq <= '0;
            cd    <= '0;
            resp  <= '0;
        end else begin
            state <= state_n;
            lives <= lives_n;
            timeq <= timeq_n;
            cd    <= cd_n;
            resp  <= resp_n;
        end
    end

    always_comb begin
        state_n = state;
        lives_n = lives;
        timeq_n = timeq;
        cd_n    = cd;
        resp_n  = resp;
        // Dropping levelStart aborts from anywhere; lives/timeLeft stay visible on the HUD.
        if (state != IDLE && !lc.levelStart) begin
            state_n = IDLE;
            cd_n    = '0;
            resp_n  = '0;
        end else begin
            unique case (state)
                IDLE: if (lc.levelStart) begin
                    state_n = COUNTDOWN;
                    lives_n = LIVES_LOAD;
                    timeq_n = (lc.levelId == LEVEL_EASY) ? TIME_E : TIME_M;
                    cd_n    = CD_LOAD;
                end
                COUNTDOWN: if (secTick) begin
                    if (cd <= 2'd1) begin
                        state_n = PLAY;
                        cd_n    = '0;
                    end else begin
                        cd_n    = cd - 1'b1;
                    end
                end
                PLAY: begin
                    if (lc.goalReached) begin
                        state_n = DONE;
                    end else if (lc.playerHit) begin
                        lives_n = (lives != '0) ? lives - 1'b1 : '0;
                        if (lives <= LIVES_W'(1)) begin
                            state_n = FAIL;
                        end else begin
                            state_n = RESPAWN;
                            resp_n  = RESP_LOAD;
                        end
                    end else if (secTick) begin
                        if (timeq <= TIME_W'(1)) begin
                            state_n = FAIL;
                            timeq_n = '0;
                        end else begin
                            timeq_n = timeq - 1'b1;
                        end
                    end else if (pauseEdge) begin
                        state_n = PAUSED;
                    end
                end
                PAUSED: if (pauseEdge) state_n = PLAY;
                RESPAWN: if (lc.frameTick) begin
                    if (resp <= 8'd1) begin
                        state_n = PLAY;
                        resp_n  = '0;
                    end else begin
                        resp_n  = resp - 1'b1;
                    end
                end
                DONE, FAIL: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign lc.levelDone = (state == DONE);
    assign lc.levelFail = (state == FAIL);
    assign lc.playing   = (state == PLAY);
    assign lc.lives     = lives;
    assign lc.timeLeft  = timeq;
    assign lc.countdown = cd;
    assign lc.stateOut  = state;

endmodule

// File: tb/tb_level_controller.sv
// Bench for level_controller: vector table, directed corner sequences, random run against a reference model.
module tb_level_controller;
    import level_pkg::*;

    localparam int FPS = 4;
    localparam int CDS = 3;
    localparam int LIV = 3;
    localparam int TE  = 5;
    localparam int TM  = 7;
    localparam int RF  = 2;

    logic Clk   = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    level_if lc();

    level_controller #(
        .FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CDS), .LIVES_INIT(LIV),
        .TIME_EASY(TE), .TIME_MED(TM), .RESPAWN_FRAMES(RF)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .lc    (lc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: game-level quantities kept as plain integers.
    level_state_t m_st;
    int m_lives, m_time, m_cd, m_frames, m_resp;
`ifdef LEVEL_PAUSE_EN
    bit m_pprev;
`endif

    typedef struct {
        int           n;
        bit           fT, lS;
        logic [1:0]   id;
        bit           pb, hit, goal;
        level_state_t st;
        int           lives, tleft, cd;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = IDLE; m_lives = 0; m_time = 0; m_cd = 0; m_frames = 0; m_resp = 0;
`ifdef LEVEL_PAUSE_EN
        m_pprev = 0;
`endif
    endtask

    task automatic model_step(input bit fT, input bit lS, input logic [1:0] id,
                              input bit pb, input bit hit, input bit goal);
        bit sec, press;
        press = 0;
`ifdef LEVEL_PAUSE_EN
        press   = pb && !m_pprev;
        m_pprev = pb;
`else
        if (pb) press = 0;
`endif
        if (m_st != IDLE && !lS) begin
            m_st = IDLE; m_frames = 0; m_resp = 0; m_cd = 0;
        end else begin
            sec = 0;
            if ((m_st == COUNTDOWN || m_st == PLAY) && fT) begin
                m_frames++;
                if (m_frames == FPS) begin m_frames = 0; sec = 1; end
            end
            case (m_st)
                IDLE: if (lS) begin
                    m_st = COUNTDOWN; m_lives = LIV; m_time = (id == 0) ? TE : TM;
                    m_cd = CDS; m_frames = 0;
                end
                COUNTDOWN: if (sec) begin
                    m_cd--;
                    if (m_cd == 0) m_st = PLAY;
                end
                PLAY: begin
                    if (goal) m_st = DONE;
                    else if (hit) begin
                        m_lives--;
                        if (m_lives == 0) m_st = FAIL;
                        else begin m_st = RESPAWN; m_resp = RF; end
                    end else if (sec) begin
                        m_time--;
                        if (m_time == 0) m_st = FAIL;
                    end else if (press) m_st = PAUSED;
                end
                RESPAWN: if (fT) begin
                    m_resp--;
                    if (m_resp == 0) m_st = PLAY;
                end
                PAUSED: if (press) m_st = PLAY;
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        logic [17:0] act, exp;
        act = {lc.stateOut, lc.levelDone, lc.levelFail, lc.playing, lc.lives, lc.timeLeft, lc.countdown};
        exp = {m_st, m_st == DONE, m_st == FAIL, m_st == PLAY, 2'(m_lives), 8'(m_time), 2'(m_cd)};
        chk("model", 32'(act), 32'(exp));
    endtask

    // Drive one cycle of inputs (called just after a rising edge), then check after the next edge.
    task automatic cyc(input bit fT, input bit lS, input logic [1:0] id,
                       input bit pb, input bit hit, input bit goal);
        lc.frameTick = fT; lc.levelStart = lS; lc.levelId = id;
        lc.pauseBtn = pb; lc.playerHit = hit; lc.goalReached = goal;
        model_step(fT, lS, id, pb, hit, goal);
        @(posedge Clk); #1;
        check_model();
    endtask

    task automatic start_play(input logic [1:0] id);
        cyc(0, 0, id, 0, 0, 0);
        cyc(0, 1, id, 0, 0, 0);
        repeat (CDS * FPS) cyc(1, 1, id, 0, 0, 0);
        chk("reach_play", 32'(lc.stateOut), 32'(PLAY));
    endtask

    initial begin
        lc.frameTick = 0; lc.levelStart = 0; lc.levelId = 0;
        lc.pauseBtn = 0; lc.playerHit = 0; lc.goalReached = 0;
        model_reset();

        tbl[0]  = '{1,  0, 0, 2'd0, 0, 0, 0, IDLE,      0, 0,  0};
        tbl[1]  = '{1,  0, 1, 2'd0, 0, 0, 0, COUNTDOWN, 3, 5,  3};
        tbl[2]  = '{4,  1, 1, 2'd0, 0, 0, 0, COUNTDOWN, 3, 5,  2};
        tbl[3]  = '{4,  1, 1, 2'd0, 0, 0, 0, COUNTDOWN, 3, 5,  1};
        tbl[4]  = '{3,  1, 1, 2'd0, 0, 0, 0, COUNTDOWN, 3, 5,  1};
        tbl[5]  = '{1,  1, 1, 2'd0, 0, 0, 0, PLAY,      3, 5,  0};
        tbl[6]  = '{4,  1, 1, 2'd0, 0, 0, 0, PLAY,      3, 4,  0};
        tbl[7]  = '{12, 1, 1, 2'd0, 0, 0, 0, PLAY,      3, 1,  0};
        tbl[8]  = '{4,  1, 1, 2'd0, 0, 0, 0, FAIL,      3, 0,  0};
        tbl[9]  = '{3,  1, 1, 2'd0, 0, 0, 0, FAIL,      3, 0,  0};
        tbl[10] = '{1,  0, 0, 2'd0, 0, 0, 0, IDLE,      3, 0,  0};
        tbl[11] = '{1,  0, 1, 2'd1, 0, 0, 0, COUNTDOWN, 3, TM, 3};
        tbl[12] = '{2,  0, 0, 2'd1, 0, 0, 0, IDLE,      3, TM, 0};

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_out", 32'({lc.stateOut, lc.levelDone, lc.levelFail, lc.playing,
                              lc.lives, lc.timeLeft, lc.countdown}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            repeat (tbl[i].n) cyc(tbl[i].fT, tbl[i].lS, tbl[i].id, tbl[i].pb, tbl[i].hit, tbl[i].goal);
            chk("tbl_state", 32'(lc.stateOut),  32'(tbl[i].st));
            chk("tbl_lives", 32'(lc.lives),     32'(tbl[i].lives));
            chk("tbl_time",  32'(lc.timeLeft),  32'(tbl[i].tleft));
            chk("tbl_cd",    32'(lc.countdown), 32'(tbl[i].cd));
        end

        // Three hits: two respawns with time frozen, then out of lives.
        start_play(2'd0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("hit1_lives", 32'(lc.lives), 32'd2);
        chk("hit1_state", 32'(lc.stateOut), 32'(RESPAWN));
        cyc(1, 1, 0, 0, 0, 0);
        chk("resp_hold", 32'(lc.stateOut), 32'(RESPAWN));
        cyc(1, 1, 0, 0, 0, 0);
        chk("resp_done", 32'(lc.stateOut), 32'(PLAY));
        chk("resp_time", 32'(lc.timeLeft), 32'd5);
        cyc(0, 1, 0, 0, 1, 0);
        chk("hit2_lives", 32'(lc.lives), 32'd1);
        cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("hit2_play", 32'(lc.stateOut), 32'(PLAY));
        cyc(0, 1, 0, 0, 1, 0);
        chk("hit3_lives", 32'(lc.lives), 32'd0);
        chk("hit3_fail", 32'(lc.levelFail), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("fail_abort", 32'(lc.stateOut), 32'(IDLE));

        // Goal beats a same-cycle hit on the last life.
        start_play(2'd0);
        cyc(0, 1, 0, 0, 1, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0);
        chk("last_life", 32'(lc.lives), 32'd1);
        cyc(0, 1, 0, 0, 1, 1);
        chk("goal_done",  32'(lc.levelDone), 32'd1);
        chk("goal_lives", 32'(lc.lives), 32'd1);
        cyc(1, 1, 0, 0, 1, 1);
        chk("done_hold", 32'(lc.stateOut), 32'(DONE));
        cyc(0, 0, 0, 0, 0, 0);
        chk("done_abort", 32'(lc.levelDone), 32'd0);

        // Pause behaviour.
        start_play(2'd0);
        cyc(0, 1, 0, 1, 0, 0);
`ifdef LEVEL_PAUSE_EN
        chk("pause_enter", 32'(lc.stateOut), 32'(PAUSED));
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, 1, 0, 0, (k == 3), 0);
        chk("pause_time",  32'(lc.timeLeft), 32'd5);
        chk("pause_lives", 32'(lc.lives), 32'd3);
        cyc(0, 1, 0, 1, 0, 0);
        chk("pause_exit", 32'(lc.stateOut), 32'(PLAY));
`else
        chk("pause_ignored", 32'(lc.stateOut), 32'(PLAY));
`endif
        cyc(0, 1, 0, 0, 0, 0);

        // Asynchronous reset mid-play clears outputs immediately.
        start_play(2'd0);
        reset = 1'b1;
        #1;
        chk("areset_out", 32'({lc.stateOut, lc.levelDone, lc.levelFail, lc.playing,
                               lc.lives, lc.timeLeft, lc.countdown}), 32'd0);
        model_reset();
        @(posedge Clk); #1;
        reset = 1'b0;
        cyc(0, 1, 0, 0, 0, 0);
        chk("post_reset_state", 32'(lc.stateOut), 32'(COUNTDOWN));
        chk("post_reset_lives", 32'(lc.lives), 32'd3);

        // Randomized run against the model.
        for (int r = 0; r < 4000; r++) begin
            bit fT, lS, pb, hit, goal;
            logic [1:0] id;
            fT   = ($urandom_range(0, 1) == 1);
            lS   = ($urandom_range(0, 63) != 0);
            pb   = ($urandom_range(0, 5) == 0);
            hit  = ($urandom_range(0, 15) == 0);
            goal = ($urandom_range(0, 79) == 0);
            id   = 2'($urandom_range(0, 3));
            cyc(fT, lS, id, pb, hit, goal);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
